// File: rtl/qoa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qoa_pkg
//  Description : Shared constants for the multi-channel QOA LMS decoder:
//                command-byte field positions, decoder state encoding and
//                fixed-point constants of the QOA predictor.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
package qoa_pkg;

    // Command byte field positions
    localparam int CMD_RES_BIT  = 0;   // 1 = residual command
    localparam int CMD_WSEL_BIT = 1;   // load: 0 = history, 1 = weight
    localparam int CMD_SEL_BIT  = 6;   // with bit7=1: 1 = channel select, 0 = TX
    localparam int CMD_TX_BIT   = 7;   // with bit0=0: 0 = load, 1 = TX/select
    localparam int SF_MSB       = 7;
    localparam int SF_LSB       = 4;
    localparam int QR_MSB       = 3;
    localparam int QR_LSB       = 1;
    localparam int TAP_MSB      = 3;
    localparam int TAP_LSB      = 2;
    localparam int CH_MSB       = 3;
    localparam int CH_LSB       = 1;

    typedef enum logic [1:0] {
        WAIT     = 2'd0,
        PARSE    = 2'd1,
        DECODE   = 2'd2,
        TXSAMPLE = 2'd3
    } qoa_state_e;

    localparam int SAMPLE_MIN  = -32768;
    localparam int SAMPLE_MAX  = 32767;
    localparam int PRED_SHIFT  = 13;
    localparam int DELTA_SHIFT = 4;
    localparam int QOA_TAPS    = 4;

endpackage
`default_nettype wire

// File: rtl/qoa_dequant_rom.sv
`default_nettype none
// ============================================================================
//  Module      : qoa_dequant_rom
//  Description : QOA dequantisation table, combinational.
//                dequant = round(scale[sf] * {0.75,2.5,4.5,7}[qr>>1]),
//                negated for odd qr, rounding half away from zero.
//  Ports       : i_sf [3:0] scale factor, i_qr [2:0] quantised residual,
//                o_dequant [15:0] signed dequantised residual.
//  Revision    : 1.0 - initial release
// ============================================================================
module qoa_dequant_rom (
    input  logic [3:0]         i_sf,
    input  logic [2:0]         i_qr,
    output logic signed [15:0] o_dequant
);

    logic [17:0] w_scale;
    logic [17:0] w_mag;

    always_comb begin
        w_scale = 18'd1;
        case (i_sf)
            4'd0:  w_scale = 18'd1;
            4'd1:  w_scale = 18'd7;
            4'd2:  w_scale = 18'd21;
            4'd3:  w_scale = 18'd45;
            4'd4:  w_scale = 18'd84;
            4'd5:  w_scale = 18'd138;
            4'd6:  w_scale = 18'd211;
            4'd7:  w_scale = 18'd304;
            4'd8:  w_scale = 18'd421;
            4'd9:  w_scale = 18'd562;
            4'd10: w_scale = 18'd731;
            4'd11: w_scale = 18'd928;
            4'd12: w_scale = 18'd1157;
            4'd13: w_scale = 18'd1419;
            4'd14: w_scale = 18'd1715;
            default: w_scale = 18'd2048;
        endcase

        // floor(k*scale + 0.5) written as integer arithmetic
        w_mag = 18'd0;
        case (i_qr[2:1])
            2'd0: w_mag = (18'd3 * w_scale + 18'd2) >> 2;
            2'd1: w_mag = (18'd5 * w_scale + 18'd1) >> 1;
            2'd2: w_mag = (18'd9 * w_scale + 18'd1) >> 1;
            default: w_mag = 18'd7 * w_scale;
        endcase

        o_dequant = i_qr[0] ? -w_mag[15:0] : w_mag[15:0];
    end

endmodule
`default_nettype wire

// File: rtl/qoa_lms_update.sv
`default_nettype none
// ============================================================================
//  Module      : qoa_lms_update
//  Description : Combinational LMS update step: prediction, sample clamp and
//                the sign-directed weight adaptation.
//                Build macro QOA_SAT_WEIGHTS_EN: weights saturate to 16 bits
//                instead of wrapping.
//  Ports       : i_acc accumulated prediction, i_dequant residual,
//                i_hist/i_wt current taps, o_sample clamped sample,
//                o_wt_next adapted weights.
//  Revision    : 1.0 - initial release
// ============================================================================
module qoa_lms_update
    import qoa_pkg::*;
#(
    parameter int ACC_W    = 32,
    parameter int LMS_TAPS = 4
) (
    input  logic signed [ACC_W-1:0] i_acc,
    input  logic signed [15:0]      i_dequant,
    input  logic signed [15:0]      i_hist    [LMS_TAPS],
    input  logic signed [15:0]      i_wt      [LMS_TAPS],
    output logic signed [15:0]      o_sample,
    output logic signed [15:0]      o_wt_next [LMS_TAPS]
);

    localparam logic signed [ACC_W-1:0] c_sample_min = ACC_W'(SAMPLE_MIN);
    localparam logic signed [ACC_W-1:0] c_sample_max = ACC_W'(SAMPLE_MAX);

    logic signed [ACC_W-1:0] w_pred;
    logic signed [ACC_W-1:0] w_uc;
    logic signed [15:0]      w_delta;

    assign w_pred  = i_acc >>> PRED_SHIFT;
    assign w_uc    = w_pred + ACC_W'(i_dequant);
    assign w_delta = i_dequant >>> DELTA_SHIFT;

    always_comb begin
        if (w_uc > c_sample_max) begin
            o_sample = 16'(SAMPLE_MAX);
        end else if (w_uc < c_sample_min) begin
            o_sample = 16'(SAMPLE_MIN);
        end else begin
            o_sample = w_uc[15:0];
        end
    end

    for (genvar t = 0; t < LMS_TAPS; t++) begin : g_tap
        logic signed [15:0] w_step;
        // Move the weight toward the sign of the history it multiplies
        assign w_step = i_hist[t][15] ? -w_delta : w_delta;
`ifdef QOA_SAT_WEIGHTS_EN
        logic signed [16:0] w_sum;
        assign w_sum = 17'(i_wt[t]) + 17'(w_step);
        assign o_wt_next[t] = (w_sum[16] != w_sum[15]) ?
                              (w_sum[16] ? 16'h8000 : 16'h7FFF) : w_sum[15:0];
`else
        assign o_wt_next[t] = i_wt[t] + w_step;
`endif
    end

endmodule
`default_nettype wire

// File: rtl/qoa_mc_lms_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : qoa_mc_lms_decoder
//  Description : Multi-channel QOA LMS sample decoder. Consumes a command
//                byte stream, keeps an independent 4-tap LMS predictor per
//                channel, decodes one residual per command and returns the
//                active channel's last sample on TX.
//                Build macro QOA_SAT_WEIGHTS_EN: saturating weight update.
//  Ports       : sys_clk, sys_rst_n (sync, active-low),
//                data_rdy/spi_in  - byte strobe and command/data byte,
//                spi_out          - sample for the output shifter,
//                busy             - residual decode in progress,
//                err_overrun      - sticky: byte arrived while busy.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
module qoa_mc_lms_decoder
    import qoa_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ACC_W    = 32,
    parameter int LMS_TAPS = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        data_rdy,
    input  logic [7:0]  spi_in,
    output logic [15:0] spi_out,
    output logic        busy,
    output logic        err_overrun
);

    localparam int c_ch_w = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (LMS_TAPS != QOA_TAPS || NUM_CH < 1 || NUM_CH > 8 || ACC_W < 32) begin : g_param_check
        $error("qoa_mc_lms_decoder: unsupported parameter set");
    end

    qoa_state_e r_state;
    qoa_state_e w_next_state;

    logic [c_ch_w-1:0]       r_active_ch;
    logic signed [15:0]      r_hist   [NUM_CH][LMS_TAPS];
    logic signed [15:0]      r_wt     [NUM_CH][LMS_TAPS];
    logic signed [15:0]      r_sample [NUM_CH];
    logic [15:0]             r_spi_out;
    logic                    r_err;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [15:0]      r_dequant;
    logic [3:0]              r_sf;
    logic [2:0]              r_qr;
    logic [2:0]              r_step;
    logic                    r_byte_idx;
    logic [7:0]              r_hi_byte;
    logic                    r_load_wt;
    logic [1:0]              r_load_tap;

    logic signed [15:0]      w_rom_dequant;
    logic signed [15:0]      w_cur_hist [LMS_TAPS];
    logic signed [15:0]      w_cur_wt   [LMS_TAPS];
    logic signed [15:0]      w_wt_next  [LMS_TAPS];
    logic signed [15:0]      w_sample;
    logic signed [31:0]      w_product;

    qoa_dequant_rom u_dequant_rom (
        .i_sf      (r_sf),
        .i_qr      (r_qr),
        .o_dequant (w_rom_dequant)
    );

    always_comb begin
        for (int t = 0; t < LMS_TAPS; t++) begin
            w_cur_hist[t] = r_hist[r_active_ch][t];
            w_cur_wt[t]   = r_wt[r_active_ch][t];
        end
    end

    // One tap per cycle; r_step 0..3 selects the tap
    assign w_product = 32'(w_cur_hist[r_step[1:0]]) * 32'(w_cur_wt[r_step[1:0]]);

    qoa_lms_update #(
        .ACC_W    (ACC_W),
        .LMS_TAPS (LMS_TAPS)
    ) u_lms_update (
        .i_acc     (r_acc),
        .i_dequant (r_dequant),
        .i_hist    (w_cur_hist),
        .i_wt      (w_cur_wt),
        .o_sample  (w_sample),
        .o_wt_next (w_wt_next)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state <= WAIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            WAIT: begin
                if (data_rdy) begin
                    if (spi_in[CMD_RES_BIT]) begin
                        w_next_state = DECODE;
                    end else if (!spi_in[CMD_TX_BIT]) begin
                        w_next_state = PARSE;
                    end else if (!spi_in[CMD_SEL_BIT]) begin
                        w_next_state = TXSAMPLE;
                    end
                end
            end
            PARSE, TXSAMPLE: begin
                if (data_rdy && r_byte_idx) begin
                    w_next_state = WAIT;
                end
            end
            DECODE: begin
                if (r_step == 3'd4) begin
                    w_next_state = WAIT;
                end
            end
            default: w_next_state = WAIT;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int t = 0; t < LMS_TAPS; t++) begin
                    r_hist[c][t] <= '0;
                    r_wt[c][t]   <= '0;
                end
                r_sample[c] <= '0;
            end
            r_active_ch <= '0;
            r_spi_out   <= '0;
            r_err       <= 1'b0;
            r_acc       <= '0;
            r_dequant   <= '0;
            r_sf        <= '0;
            r_qr        <= '0;
            r_step      <= '0;
            r_byte_idx  <= 1'b0;
            r_hi_byte   <= '0;
            r_load_wt   <= 1'b0;
            r_load_tap  <= '0;
        end else begin
            case (r_state)
                WAIT: begin
                    r_byte_idx <= 1'b0;
                    r_step     <= '0;
                    if (data_rdy) begin
                        if (spi_in[CMD_RES_BIT]) begin
                            r_sf <= spi_in[SF_MSB:SF_LSB];
                            r_qr <= spi_in[QR_MSB:QR_LSB];
                        end else if (!spi_in[CMD_TX_BIT]) begin
                            r_load_wt  <= spi_in[CMD_WSEL_BIT];
                            r_load_tap <= spi_in[TAP_MSB:TAP_LSB];
                        end else if (!spi_in[CMD_SEL_BIT]) begin
                            r_spi_out <= r_sample[r_active_ch];
                        end else if (int'(spi_in[CH_MSB:CH_LSB]) < NUM_CH) begin
                            r_active_ch <= spi_in[CH_LSB +: c_ch_w];
                        end
                    end
                end
                PARSE: begin
                    if (data_rdy) begin
                        if (!r_byte_idx) begin
                            r_hi_byte  <= spi_in;
                            r_byte_idx <= 1'b1;
                        end else if (r_load_wt) begin
                            r_wt[r_active_ch][r_load_tap] <= {r_hi_byte, spi_in};
                        end else begin
                            r_hist[r_active_ch][r_load_tap] <= {r_hi_byte, spi_in};
                        end
                    end
                end
                TXSAMPLE: begin
                    if (data_rdy) begin
                        r_byte_idx <= 1'b1;
                    end
                end
                DECODE: begin
                    if (data_rdy) begin
                        r_err <= 1'b1;
                    end
                    r_step <= r_step + 3'd1;
                    if (r_step == 3'd0) begin
                        r_dequant <= w_rom_dequant;
                    end
                    if (r_step != 3'd4) begin
                        r_acc <= r_acc + ACC_W'(w_product);
                    end else begin
                        // Update: weights adapt against the pre-shift history
                        for (int t = 0; t < LMS_TAPS; t++) begin
                            r_wt[r_active_ch][t] <= w_wt_next[t];
                        end
                        for (int t = 0; t < LMS_TAPS - 1; t++) begin
                            r_hist[r_active_ch][t] <= r_hist[r_active_ch][t+1];
                        end
                        r_hist[r_active_ch][LMS_TAPS-1] <= w_sample;
                        r_sample[r_active_ch]           <= w_sample;
                        r_acc                           <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign spi_out     = r_spi_out;
    assign busy        = (r_state == DECODE);
    assign err_overrun = r_err;

endmodule
`default_nettype wire

// File: tb/tb_qoa_mc_lms_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qoa_mc_lms_decoder
//  Description : Self-checking bench for qoa_mc_lms_decoder. A command-level
//                reference model predicts each TX result into a scoreboard
//                queue; a monitor pops and compares when a TX completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qoa_mc_lms_decoder;

    localparam int NUM_CH = 2;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        data_rdy  = 1'b0;
    logic [7:0]  spi_in    = 8'h00;
    logic [15:0] spi_out;
    logic        busy;
    logic        err_overrun;

    always #5 sys_clk = ~sys_clk;

    qoa_mc_lms_decoder #(
        .NUM_CH   (NUM_CH),
        .ACC_W    (32),
        .LMS_TAPS (4)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .data_rdy    (data_rdy),
        .spi_in      (spi_in),
        .spi_out     (spi_out),
        .busy        (busy),
        .err_overrun (err_overrun)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [15:0] smp;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    event tx_done;

    // Reference model state
    shortint m_hist [NUM_CH][4];
    shortint m_wt   [NUM_CH][4];
    shortint m_smp  [NUM_CH];
    int      m_active;
    bit      m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            for (int t = 0; t < 4; t++) begin
                m_hist[c][t] = 0;
                m_wt[c][t]   = 0;
            end
            m_smp[c] = 0;
        end
        m_active = 0;
        m_err    = 1'b0;
    endfunction

    // round(scale * k), scale = round((sf+1)^2.75), odd qr negates
    function automatic int model_dequant(input int sf, input int qr);
        real k;
        int  scale;
        int  mag;
        case (qr / 2)
            0:       k = 0.75;
            1:       k = 2.5;
            2:       k = 4.5;
            default: k = 7.0;
        endcase
        scale = int'($pow(real'(sf + 1), 2.75));
        mag   = int'(real'(scale) * k);
        return (qr % 2 != 0) ? -mag : mag;
    endfunction

    function automatic void model_decode(input logic [7:0] b);
        int c, dq, acc, pred, uc, smp, delta, step, nw;
        c   = m_active;
        dq  = model_dequant(int'(b[7:4]), int'(b[3:1]));
        acc = 0;
        for (int t = 0; t < 4; t++) acc += int'(m_hist[c][t]) * int'(m_wt[c][t]);
        pred  = acc >>> 13;
        uc    = pred + dq;
        smp   = (uc > 32767) ? 32767 : ((uc < -32768) ? -32768 : uc);
        delta = dq >>> 4;
        for (int t = 0; t < 4; t++) begin
            step = (m_hist[c][t] < 0) ? -delta : delta;
            nw   = int'(m_wt[c][t]) + step;
`ifdef QOA_SAT_WEIGHTS_EN
            if (nw > 32767) nw = 32767;
            if (nw < -32768) nw = -32768;
`endif
            m_wt[c][t] = shortint'(nw);
        end
        for (int t = 0; t < 3; t++) m_hist[c][t] = m_hist[c][t+1];
        m_hist[c][3] = shortint'(smp);
        m_smp[c]     = shortint'(smp);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        data_rdy = 1'b1;
        spi_in   = b;
        @(negedge sys_clk);
        data_rdy = 1'b0;
        spi_in   = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 20) begin
            n_cmp++;
            n_fail++;
            $display("FAIL busy_timeout: busy still %0b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic cmd_load(input int tap, input bit is_wt, input logic [15:0] val);
        send_byte({4'b0000, 2'(tap), is_wt, 1'b0});
        send_byte(val[15:8]);
        send_byte(val[7:0]);
        if (is_wt) m_wt[m_active][tap] = shortint'(val);
        else       m_hist[m_active][tap] = shortint'(val);
    endtask

    task automatic cmd_res(input logic [7:0] b);
        send_byte(b);
        model_decode(b);
        wait_idle();
    endtask

    task automatic cmd_sel(input logic [7:0] b);
        send_byte(b);
        if (int'(b[3:1]) < NUM_CH) m_active = int'(b[3:1]);
    endtask

    task automatic cmd_tx();
        exp_t e;
        e.smp = 16'(m_smp[m_active]);
        e.err = m_err;
        sb_q.push_back(e);
        send_byte(8'h80);
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        -> tx_done;
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(tx_done);
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_underflow: got TX with empty queue, required an entry");
            end else begin
                e = sb_q.pop_front();
                check("tx_spi_out", 32'(spi_out), 32'(e.smp));
                check("tx_err_overrun", 32'(err_overrun), 32'(e.err));
            end
        end
    end

    // Every busy pulse lasts exactly five cycles
    initial begin
        int len = 0;
        forever begin
            @(negedge sys_clk);
            if (busy) begin
                len++;
            end else if (len != 0) begin
                check("busy_width", 32'(len), 32'd5);
                len = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("reset_spi_out", 32'(spi_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_err", 32'(err_overrun), 32'd0);
        cmd_tx();

        // First decode on ch0: 0x100*0x2000>>13 + 1
        cmd_load(3, 1'b1, 16'h2000);
        cmd_load(3, 1'b0, 16'h0100);
        cmd_res(8'h01);
        cmd_tx();
        check("first_decode", 32'(spi_out), 32'h0101);

        // Channel isolation and out-of-range select
        cmd_sel(8'hC2);
        cmd_tx();
        check("ch1_untouched", 32'(spi_out), 32'h0000);
        cmd_sel(8'hC0);
        cmd_tx();
        cmd_sel(8'hCE);
        cmd_tx();
        check("bad_select_ignored", 32'(spi_out), 32'h0101);

        // Clamping
        cmd_load(3, 1'b0, 16'h7FFF);
        cmd_load(3, 1'b1, 16'h7FFF);
        cmd_res(8'h01);
        cmd_tx();
        check("clamp_high", 32'(spi_out), 32'h7FFF);
        cmd_load(3, 1'b0, 16'h8000);
        cmd_res(8'h01);
        cmd_tx();
        check("clamp_low", 32'(spi_out), 32'h8000);

        // Weight overflow, revealed by h0=0x2000 making pred equal w0
        cmd_load(0, 1'b1, 16'h7FF0);
        cmd_load(0, 1'b0, 16'h0001);
        cmd_res(8'hF1);
        cmd_load(0, 1'b0, 16'h2000);
        for (int t = 1; t < 4; t++) begin
            cmd_load(t, 1'b0, 16'h0000);
            cmd_load(t, 1'b1, 16'h0000);
        end
        cmd_res(8'h01);
        cmd_tx();
`ifdef QOA_SAT_WEIGHTS_EN
        check("weight_saturate", 32'(spi_out), 32'h7FFF);
`else
        check("weight_wrap", 32'(spi_out), 32'h8051);
`endif

        // Overrun: stray byte during cycle 3 of a decode
        cmd_load(3, 1'b0, 16'h1234);
        cmd_load(3, 1'b1, 16'h1000);
        send_byte(8'h35);
        model_decode(8'h35);
        @(negedge sys_clk);
        @(negedge sys_clk);
        send_byte(8'h01);
        m_err = 1'b1;
        wait_idle();
        cmd_tx();

        // Randomised command mix
        for (int i = 0; i < 150; i++) begin
            int r;
            r = int'($urandom_range(0, 8));
            if (r <= 2)      cmd_load(int'($urandom_range(0, 3)), 1'($urandom), 16'($urandom));
            else if (r <= 5) cmd_res({7'($urandom), 1'b1});
            else if (r == 6) cmd_sel({4'hC, 3'($urandom), 1'b0});
            else             cmd_tx();
        end
        cmd_tx();

        repeat (5) @(negedge sys_clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        // Reset clears the sticky flag and all channel state
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        model_reset();
        @(negedge sys_clk);
        check("rereset_spi_out", 32'(spi_out), 32'd0);
        check("rereset_err", 32'(err_overrun), 32'd0);
        cmd_tx();
        repeat (3) @(negedge sys_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
